// File: rtl/par_stat_sink_if.sv
// Local eject port of one NoC node: flit source (router) to sink.
// The flit transfers on a posedge where valid=1 and busy=0; while busy=1 the
// source holds valid and data stable and the sink ignores data.
interface par_stat_sink_if #(
    parameter int FLIT_W = 22
);
    logic              valid;
    logic [FLIT_W-1:0] data;
    logic              busy;

    modport master (output valid, output data, input busy);
    modport slave  (input valid, input data, output busy);
endinterface

// File: rtl/par_stat_sink.sv
// Terminating sink for a NoC node: throttles acceptance by hospitality mode,
// checks destinations and accumulates delivery, per-source and latency stats.
module par_stat_sink #(
    parameter int           NODE_ID = 0,
    parameter int           ADDR_W  = 4,
    parameter int           PL_W    = 16,
    parameter int           HDR_W   = 2,
    parameter int           SRC_W   = 4,
    parameter int           TS_W    = 12,
    parameter int           NUM_SRC = 9,
    parameter int           CNT_W   = 20,
    parameter int           MODE    = 1,
    parameter int           HOSP    = 255,
    parameter logic [7:0]   SEED    = 8'hA5
) (
    input  logic                         clk,
    input  logic                         reset,
    par_stat_sink_if.slave               s_flit,
    input  logic [TS_W-1:0]              i_now,
    input  logic                         i_clear,
    input  logic [SRC_W-1:0]             i_rd_src,
    output logic [CNT_W-1:0]             o_rx_count,
    output logic [CNT_W-1:0]             o_err_count,
    output logic [CNT_W-1:0]             o_src_count,
    output logic [CNT_W+TS_W-1:0]        o_lat_sum,
    output logic [TS_W-1:0]              o_lat_max,
    output logic [HDR_W+PL_W+ADDR_W-1:0] o_last_flit
);
    localparam int                   FLIT_W  = HDR_W + PL_W + ADDR_W;
    localparam int                   SUM_W   = CNT_W + TS_W;
    localparam logic [7:0]           HOSP_L  = HOSP[7:0];
    localparam logic [ADDR_W-1:0]    NODE_L  = NODE_ID[ADDR_W-1:0];
    localparam logic [SRC_W:0]       NSRC_L  = NUM_SRC[SRC_W:0];
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;
    localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0]     SUM_MAX = '1;

    logic [7:0]        r_lfsr;
    logic [7:0]        r_period;
    logic              r_busy;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_src_cnt [NUM_SRC];
    logic [SUM_W-1:0]  r_lat_sum;
    logic [TS_W-1:0]   r_lat_max;
    logic [FLIT_W-1:0] r_last_flit;

    logic [7:0]        w_lfsr_next;
    logic [7:0]        w_period_next;
    logic              w_busy_next;
    logic              w_accept;
    logic [ADDR_W-1:0] w_dest;
    logic [SRC_W-1:0]  w_src;
    logic [TS_W-1:0]   w_ts;
    logic              w_err;
    logic [TS_W-1:0]   w_lat;
    logic [SUM_W:0]    w_sum_wide;
    logic [SUM_W-1:0]  w_sum_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
    assign w_lfsr_next   = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_period_next = r_period + 8'd1;

    always_comb begin
        w_busy_next = 1'b0;
        if (HOSP_L != 8'hFF) begin
            case (MODE)
                1:       w_busy_next = (w_lfsr_next >= HOSP_L);
                2:       w_busy_next = (w_period_next >= HOSP_L);
                default: w_busy_next = 1'b0;
            endcase
        end
    end

    assign w_accept   = s_flit.valid & ~r_busy;
    assign w_dest     = s_flit.data[ADDR_W-1:0];
    assign w_src      = s_flit.data[ADDR_W +: SRC_W];
    assign w_ts       = s_flit.data[ADDR_W+SRC_W +: TS_W];
    assign w_err      = (w_dest != NODE_L) | ({1'b0, w_src} >= NSRC_L);
    assign w_lat      = i_now - w_ts;
    assign w_sum_wide = {1'b0, r_lat_sum} + {{(CNT_W+1){1'b0}}, w_lat};
    assign w_sum_next = w_sum_wide[SUM_W] ? SUM_MAX : w_sum_wide[SUM_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr      <= SEED;
            r_period    <= 8'd0;
            r_busy      <= 1'b1;
            r_rx_cnt    <= '0;
            r_err_cnt   <= '0;
            r_lat_sum   <= '0;
            r_lat_max   <= '0;
            r_last_flit <= '0;
            for (int i = 0; i < NUM_SRC; i++) r_src_cnt[i] <= '0;
        end else begin
            r_lfsr   <= w_lfsr_next;
            r_period <= w_period_next;
            r_busy   <= w_busy_next;
            if (w_accept) r_last_flit <= s_flit.data;
            // Clear outranks a same-edge accept: the flit is taken but not counted.
            if (i_clear) begin
                r_rx_cnt  <= '0;
                r_err_cnt <= '0;
                r_lat_sum <= '0;
                r_lat_max <= '0;
                for (int i = 0; i < NUM_SRC; i++) r_src_cnt[i] <= '0;
            end else if (w_accept) begin
                if (w_err) begin
                    r_err_cnt <= sat_inc(r_err_cnt);
                end else begin
                    r_rx_cnt  <= sat_inc(r_rx_cnt);
                    r_lat_sum <= w_sum_next;
                    if (w_lat > r_lat_max) r_lat_max <= w_lat;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (w_src == i[SRC_W-1:0]) r_src_cnt[i] <= sat_inc(r_src_cnt[i]);
                    end
                end
            end
        end
    end

    always_comb begin
        o_src_count = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_rd_src == i[SRC_W-1:0]) o_src_count = r_src_cnt[i];
        end
    end

    assign s_flit.busy = r_busy;
    assign o_rx_count  = r_rx_cnt;
    assign o_err_count = r_err_cnt;
    assign o_lat_sum   = r_lat_sum;
    assign o_lat_max   = r_lat_max;
    assign o_last_flit = r_last_flit;
endmodule

// File: tb/tb_par_stat_sink.sv
// Bench for par_stat_sink: three instances (always-accept, periodic with narrow
// counters, LFSR-random) driven from one sequence with a last-flit scoreboard.
module tb_par_stat_sink;
    localparam int FW   = 22;
    localparam int TS_W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ab, rst_c;
    logic [TS_W-1:0] now_a, now_b, now_c;
    logic clear_a, clear_b, clear_c;
    logic [3:0] rd_a, rd_b, rd_c;

    logic [19:0] a_rx, a_err, a_src;
    logic [31:0] a_sum;
    logic [11:0] a_max;
    logic [FW-1:0] a_last;
    logic [3:0] b_rx, b_err, b_src;
    logic [15:0] b_sum;
    logic [11:0] b_max;
    logic [FW-1:0] b_last;
    logic [19:0] c_rx, c_err, c_src;
    logic [31:0] c_sum;
    logic [11:0] c_max;
    logic [FW-1:0] c_last;

    par_stat_sink_if #(.FLIT_W(FW)) if_a ();
    par_stat_sink_if #(.FLIT_W(FW)) if_b ();
    par_stat_sink_if #(.FLIT_W(FW)) if_c ();

    par_stat_sink #(.MODE(0), .HOSP(255)) u_a (
        .clk(clk), .reset(rst_ab), .s_flit(if_a), .i_now(now_a), .i_clear(clear_a),
        .i_rd_src(rd_a), .o_rx_count(a_rx), .o_err_count(a_err), .o_src_count(a_src),
        .o_lat_sum(a_sum), .o_lat_max(a_max), .o_last_flit(a_last));

    par_stat_sink #(.NODE_ID(3), .CNT_W(4), .MODE(2), .HOSP(64)) u_b (
        .clk(clk), .reset(rst_ab), .s_flit(if_b), .i_now(now_b), .i_clear(clear_b),
        .i_rd_src(rd_b), .o_rx_count(b_rx), .o_err_count(b_err), .o_src_count(b_src),
        .o_lat_sum(b_sum), .o_lat_max(b_max), .o_last_flit(b_last));

    par_stat_sink #(.MODE(1), .HOSP(128)) u_c (
        .clk(clk), .reset(rst_c), .s_flit(if_c), .i_now(now_c), .i_clear(clear_c),
        .i_rd_src(rd_c), .o_rx_count(c_rx), .o_err_count(c_err), .o_src_count(c_src),
        .o_lat_sum(c_sum), .o_lat_max(c_max), .o_last_flit(c_last));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard and reference model, index 0 = u_a, 1 = u_b.
    logic [FW-1:0] exp_q[$];
    int     exp_rx  [2];
    int     exp_err [2];
    int     exp_src [2][16];
    longint exp_sum [2];
    int     exp_max [2];

    function automatic int cmax(input int inst);
        return (inst == 0) ? 20'hFFFFF : 4'hF;
    endfunction
    function automatic longint smax(input int inst);
        return (inst == 0) ? 64'hFFFF_FFFF : 64'hFFFF;
    endfunction
    function automatic logic [3:0] node_of(input int inst);
        return (inst == 0) ? 4'd0 : 4'd3;
    endfunction

    function automatic void model_clear(input int inst);
        exp_rx[inst] = 0; exp_err[inst] = 0; exp_sum[inst] = 0; exp_max[inst] = 0;
        for (int k = 0; k < 16; k++) exp_src[inst][k] = 0;
    endfunction

    function automatic void model_accept(input int inst, input logic [FW-1:0] f,
                                         input logic [TS_W-1:0] t_now, input logic clr);
        logic [3:0]  dest, src;
        logic [11:0] lat;
        dest = f[3:0];
        src  = f[7:4];
        lat  = t_now - f[19:8];
        if (clr) model_clear(inst);
        else if (dest != node_of(inst) || src >= 4'd9) begin
            if (exp_err[inst] < cmax(inst)) exp_err[inst]++;
        end else begin
            if (exp_rx[inst] < cmax(inst)) exp_rx[inst]++;
            if (exp_src[inst][src] < cmax(inst)) exp_src[inst][src]++;
            exp_sum[inst] = exp_sum[inst] + longint'(lat);
            if (exp_sum[inst] > smax(inst)) exp_sum[inst] = smax(inst);
            if (int'(lat) > exp_max[inst]) exp_max[inst] = int'(lat);
        end
    endfunction

    function automatic logic [FW-1:0] mk_flit(input logic [3:0] dest, input logic [3:0] src,
                                              input logic [11:0] ts);
        logic [1:0] hdr;
        hdr = 2'($urandom_range(0, 3));
        return {hdr, ts, src, dest};
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic send(input int inst, input logic [FW-1:0] f, input logic [TS_W-1:0] t_now,
                        input logic clr);
        int   n;
        logic bsy;
        @(negedge clk);
        if (inst == 0) begin if_a.valid = 1'b1; if_a.data = f; now_a = t_now; clear_a = clr; end
        else           begin if_b.valid = 1'b1; if_b.data = f; now_b = t_now; clear_b = clr; end
        n   = 0;
        bsy = (inst == 0) ? if_a.busy : if_b.busy;
        while (bsy && n < 600) begin
            @(negedge clk);
            n++;
            bsy = (inst == 0) ? if_a.busy : if_b.busy;
        end
        check_eq("accept_ready", {63'd0, bsy}, 64'd0);
        exp_q.push_back(f);
        model_accept(inst, f, t_now, clr);
        @(posedge clk);
        #1;
        if (inst == 0) begin if_a.valid = 1'b0; clear_a = 1'b0; end
        else           begin if_b.valid = 1'b0; clear_b = 1'b0; end
        @(negedge clk);
        check_eq("last_flit", (inst == 0) ? a_last : b_last, exp_q.pop_front());
    endtask

    task automatic pulse_clear(input int inst);
        @(negedge clk);
        if (inst == 0) clear_a = 1'b1; else clear_b = 1'b1;
        model_clear(inst);
        @(posedge clk);
        #1;
        clear_a = 1'b0;
        clear_b = 1'b0;
    endtask

    task automatic check_stats(input int inst, input string tag);
        @(negedge clk);
        check_eq({tag, "_rx"},  (inst == 0) ? 64'(a_rx)  : 64'(b_rx),  64'(exp_rx[inst]));
        check_eq({tag, "_err"}, (inst == 0) ? 64'(a_err) : 64'(b_err), 64'(exp_err[inst]));
        check_eq({tag, "_sum"}, (inst == 0) ? 64'(a_sum) : 64'(b_sum), 64'(exp_sum[inst]));
        check_eq({tag, "_max"}, (inst == 0) ? 64'(a_max) : 64'(b_max), 64'(exp_max[inst]));
        for (int k = 0; k < 16; k++) begin
            rd_a = 4'(k);
            rd_b = 4'(k);
            #1;
            check_eq($sformatf("%s_src%0d", tag, k), (inst == 0) ? 64'(a_src) : 64'(b_src),
                     64'(exp_src[inst][k]));
        end
    endtask

    logic t1_on = 1'b0;
    int   busy_hits_a = 0;
    always @(negedge clk) if (t1_on && if_a.busy) busy_hits_a++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  lf;
        logic        ref_busy [40];
        int          acc, run, full_runs, bad_runs, acc_c;
        logic [11:0] t;

        rst_ab = 1'b0; rst_c = 1'b0;
        now_a = '0; now_b = '0; now_c = '0;
        clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
        rd_a = '0; rd_b = '0; rd_c = '0;
        if_a.valid = 1'b0; if_a.data = '0;
        if_b.valid = 1'b0; if_b.data = '0;
        if_c.valid = 1'b0; if_c.data = '0;
        model_clear(0);
        model_clear(1);

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy_a", {63'd0, if_a.busy}, 64'd1);
        check_eq("rst_busy_b", {63'd0, if_b.busy}, 64'd1);
        check_eq("rst_busy_c", {63'd0, if_c.busy}, 64'd1);
        check_eq("rst_rx_a", 64'(a_rx), 64'd0);
        check_eq("rst_sum_a", 64'(a_sum), 64'd0);
        check_eq("rst_last_a", 64'(a_last), 64'd0);
        rst_ab = 1'b1;
        @(negedge clk);
        check_eq("rel_busy_a", {63'd0, if_a.busy}, 64'd0);
        check_eq("rel_busy_b", {63'd0, if_b.busy}, 64'd0);

        // T1: nine good flits from every source, latency 3
        t1_on = 1'b1;
        for (int i = 0; i < 9; i++) begin
            t = 12'(100 + i * 37);
            send(0, mk_flit(4'd0, 4'(i), t - 12'd3), t, 1'b0);
        end
        t1_on = 1'b0;
        check_eq("t1_busy_seen", 64'(busy_hits_a), 64'd0);
        check_stats(0, "t1");
        check_eq("t1_rx9", 64'(a_rx), 64'd9);
        check_eq("t1_sum27", 64'(a_sum), 64'd27);
        check_eq("t1_max3", 64'(a_max), 64'd3);

        // T2: wrong destinations, then an out-of-range source
        pulse_clear(0);
        check_stats(0, "t2_clr");
        for (int i = 0; i < 3; i++)
            send(0, mk_flit(4'd1, 4'($urandom_range(0, 8)), 12'($urandom_range(0, 4095))),
                 12'($urandom_range(0, 4095)), 1'b0);
        send(0, mk_flit(4'd0, 4'd12, 12'd50), 12'd60, 1'b0);
        check_stats(0, "t2");
        check_eq("t2_err4", 64'(a_err), 64'd4);
        check_eq("t2_rx0", 64'(a_rx), 64'd0);

        // T5: timestamp wrap, then clear colliding with an accept
        pulse_clear(0);
        send(0, mk_flit(4'd0, 4'd1, 12'd4090), 12'd5, 1'b0);
        send(0, mk_flit(4'd0, 4'd5, 12'd0), 12'd100, 1'b0);
        check_stats(0, "t5");
        check_eq("t5_max100", 64'(a_max), 64'd100);
        check_eq("t5_sum111", 64'(a_sum), 64'd111);
        send(0, mk_flit(4'd0, 4'd3, 12'd7), 12'd20, 1'b1);
        check_stats(0, "t5_clr");

        // T3: periodic duty, valid held for 512 cycles with an error flit
        @(negedge clk);
        if_b.valid = 1'b1;
        if_b.data  = mk_flit(4'd5, 4'd0, 12'd0);
        acc = 0; run = -1; full_runs = 0; bad_runs = 0;
        for (int k = 0; k < 512; k++) begin
            if (!if_b.busy) begin
                acc++;
                if (run > 0) begin
                    full_runs++;
                    if (run != 192) bad_runs++;
                end
                run = 0;
            end else if (run >= 0) begin
                run++;
            end
            @(negedge clk);
        end
        if_b.valid = 1'b0;
        check_eq("t3_accepts", 64'(acc), 64'd128);
        check_eq("t3_bad_runs", 64'(bad_runs), 64'd0);
        check_eq("t3_full_run_seen", {63'd0, full_runs >= 1}, 64'd1);
        @(negedge clk);
        check_eq("t3_err_sat", 64'(b_err), 64'd15);

        // T4: 4-bit counters saturate; max latency drives lat_sum to all-ones
        pulse_clear(1);
        for (int i = 0; i < 20; i++) begin
            t = 12'($urandom_range(0, 4095));
            send(1, mk_flit(4'd3, 4'd2, t + 12'd1), t, 1'b0);
        end
        check_stats(1, "t4");
        check_eq("t4_rx15", 64'(b_rx), 64'd15);
        rd_b = 4'd2;
        #1;
        check_eq("t4_src2_15", 64'(b_src), 64'd15);
        check_eq("t4_sum_sat", 64'(b_sum), 64'hFFFF);
        check_eq("t4_max4095", 64'(b_max), 64'd4095);

        // T6: LFSR mode, busy pattern from SEED, mid-stream reset
        @(negedge clk);
        if_c.valid = 1'b1;
        if_c.data  = mk_flit(4'd0, 4'd1, 12'd0);
        now_c      = 12'd0;
        rst_c      = 1'b1;
        lf         = 8'hA5;
        acc_c      = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            lf = lfsr_step(lf);
            @(negedge clk);
            ref_busy[k] = if_c.busy;
            check_eq($sformatf("t6_busy%0d", k), {63'd0, if_c.busy}, {63'd0, lf >= 8'd128});
            if (k < 39 && !(lf >= 8'd128)) acc_c++;
        end
        check_eq("t6_rx", 64'(c_rx), 64'(acc_c));
        check_eq("t6_last", 64'(c_last), (acc_c > 0) ? 64'(if_c.data) : 64'd0);
        #2 rst_c = 1'b0;
        #1;
        check_eq("t6_rst_busy", {63'd0, if_c.busy}, 64'd1);
        check_eq("t6_rst_rx", 64'(c_rx), 64'd0);
        check_eq("t6_rst_sum", 64'(c_sum), 64'd0);
        check_eq("t6_rst_last", 64'(c_last), 64'd0);
        @(negedge clk);
        rst_c = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check_eq($sformatf("t6_repeat%0d", k), {63'd0, if_c.busy}, {63'd0, ref_busy[k]});
        end
        if_c.valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
